// File: rtl/processorc_port_pkg.sv
// processorc_port_pkg: default port/tag sizing and the port-index type.
// These values are also used by the round-robin port arbiter.
package processorc_port_pkg;
    localparam int DEF_PORTCOUNT = 4;
    localparam int DEF_PORTADDRWIDTH = 2;
    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_TAGDEPTH = 4;
    typedef logic [DEF_PORTADDRWIDTH-1:0] port_idx_t;
endpackage

// File: rtl/port_tag_fifo.sv
// port_tag_fifo: synchronous FIFO with push/pop, full/empty and occupancy count.
// There is no full-bypass: a push while full is dropped even if a pop happens in the same cycle.
module port_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int DEPTHWIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  sync_rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTHWIDTH:0]   count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTHWIDTH-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (DEPTHWIDTH+1)'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_data;
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTHWIDTH'(1);
            if (do_pop) rd_ptr <= rd_ptr + DEPTHWIDTH'(1);
            count <= count + (DEPTHWIDTH+1)'(do_push) - (DEPTHWIDTH+1)'(do_pop);
        end
    end
endmodule

// File: rtl/port_response_router.sv
// port_response_router: steers in-order responses back to the port that issued each request.
// Define PORT_RESPONSE_ROUTER_OUTREG_EN for a one-entry registered output stage (1-cycle latency).
module port_response_router
    import processorc_port_pkg::*;
#(
    parameter int PORTCOUNT = DEF_PORTCOUNT,
    parameter int PORTADDRWIDTH = DEF_PORTADDRWIDTH,
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int TAGDEPTH = DEF_TAGDEPTH,
    parameter int TAGDEPTHWIDTH = $clog2(TAGDEPTH)
) (
    input  logic                     clk,
    input  logic                     clk_en,
    input  logic                     sync_rst,
    input  logic                     IssueValid,
    input  logic [PORTADDRWIDTH-1:0] IssuePort,
    output logic                     IssueReady,
    input  logic                     RespValid,
    input  logic [DATAWIDTH-1:0]     RespData,
    output logic                     RespReady,
    output logic [PORTCOUNT-1:0]     PortRespValid,
    output logic [DATAWIDTH-1:0]     PortRespData,
    input  logic [PORTCOUNT-1:0]     PortRespReady,
    output logic [TAGDEPTHWIDTH:0]   OutstandingCount,
    output logic                     ProtocolError
);
    logic push, pop, full, empty, live, head_ok, err_q;
    logic [PORTADDRWIDTH-1:0] head;
    logic [PORTCOUNT-1:0] sel;

    port_tag_fifo #(.WIDTH(PORTADDRWIDTH), .DEPTH(TAGDEPTH), .DEPTHWIDTH(TAGDEPTHWIDTH)) u_fifo (
        .clk(clk), .sync_rst(sync_rst), .push(push), .push_data(IssuePort), .pop(pop),
        .head(head), .full(full), .empty(empty), .count(OutstandingCount)
    );

    // A response in the reset cycle is never routed or accepted.
    assign live = !empty && !sync_rst;
    assign head_ok = 32'(head) < PORTCOUNT;
    assign sel = head_ok ? PORTCOUNT'(1) << head : '0;
    assign IssueReady = clk_en && !full;
    assign push = IssueValid && IssueReady;
    assign pop = RespValid && RespReady;
    assign ProtocolError = err_q;

    always_ff @(posedge clk) begin
        if (sync_rst) err_q <= 1'b0;
        else if (clk_en && RespValid && (!live || !head_ok)) err_q <= 1'b1;
    end

`ifdef PORT_RESPONSE_ROUTER_OUTREG_EN
    logic [PORTCOUNT-1:0] stage_vld;
    logic [DATAWIDTH-1:0] stage_data;
    logic drain;
    assign drain = clk_en && |(stage_vld & PortRespReady);
    assign RespReady = clk_en && live && (!head_ok || stage_vld == '0 || drain);
    assign PortRespValid = stage_vld;
    assign PortRespData = stage_data;
    // Out-of-range responses are popped but never loaded into the stage.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            stage_vld <= '0;
            stage_data <= '0;
        end else if (clk_en) begin
            if (pop && head_ok) begin
                stage_vld <= sel;
                stage_data <= RespData;
            end else if (drain) begin
                stage_vld <= '0;
            end
        end
    end
`else
    assign RespReady = clk_en && live && (!head_ok || PortRespReady[head]);
    assign PortRespValid = (RespValid && live) ? sel : '0;
    assign PortRespData = RespData;
`endif
endmodule
